// File: rtl/sr_debounce_pkg.sv
// Shared constants for the push-button debouncer feeding the NAND SR latch.
package sr_debounce_pkg;

  // Default number of consecutive synchronized cycles a new level must hold.
  localparam int unsigned DEF_STABLE_CYCLES = 200;

  // Default width of each debounce counter (2**DEF_CNT_W > DEF_STABLE_CYCLES).
  localparam int unsigned DEF_CNT_W = 8;

  // Level of an active-low strobe when no request is being issued.
  localparam logic STROBE_IDLE = 1'b1;

endpackage : sr_debounce_pkg

// File: rtl/sr_debounce_ch.sv
// One debounce channel: 2-flop synchronizer, stability counter, debounced
// level register and a registered one-cycle request on each 0->1 level change.
module debounce_ch #(
  parameter int unsigned STABLE_CYCLES = 200,
  parameter int unsigned CNT_W         = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic lvl,
  output logic req
);

  // Counter value at which a still-differing input is accepted.
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lvl_q, lvl_d;
  logic             lvl_prev_q, lvl_prev_d;
  logic             req_q, req_d;

  // Next-state logic: synchronizer shift, stability count, level toggle, edge request.
  always_comb begin
    // NOTE: every _d is given a default first so no path leaves it unassigned, which keeps this block free of inferred latches.
    sync1_d    = btn;
    sync2_d    = sync1_q;
    cnt_d      = cnt_q;
    lvl_d      = lvl_q;
    lvl_prev_d = lvl_q;
    req_d      = lvl_q & ~lvl_prev_q;

    if (sync2_q == lvl_q) begin
      // Input agrees with the accepted level (or a glitch reverted): restart.
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      // Held long enough: accept the new level; counter never passes CNT_MAX.
      lvl_d = ~lvl_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is assigned with non-blocking (<=) so every flop samples pre-edge values and the order of statements does not matter.
    if (!rst_n) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      cnt_q      <= '0;
      lvl_q      <= 1'b0;
      lvl_prev_q <= 1'b0;
      req_q      <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      cnt_q      <= cnt_d;
      lvl_q      <= lvl_d;
      lvl_prev_q <= lvl_prev_d;
      req_q      <= req_d;
    end
  end

  assign lvl = lvl_q;
  assign req = req_q;

endmodule : debounce_ch

// File: rtl/sr_debounce.sv
// Debounces the set/reset buttons and arbitrates their requests into
// registered, mutually exclusive, active-low one-cycle strobes.
// Reset wins a collision; the losing set waits in a one-bit pending flag.
module sr_debounce
  import sr_debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned CNT_W         = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_set,
  input  logic btn_rst,
  output logic s_n,
  output logic r_n,
  output logic set_lvl,
  output logic rst_lvl
);

  logic req_s, req_r;
  logic set_want;
  logic pend_q, pend_d;
  logic s_n_q, s_n_d;
  logic r_n_q, r_n_d;

  debounce_ch #(
    .STABLE_CYCLES(STABLE_CYCLES),
    .CNT_W        (CNT_W)
  ) u_set_ch (
    .clk  (clk),
    .rst_n(rst_n),
    .btn  (btn_set),
    .lvl  (set_lvl),
    .req  (req_s)
  );

  debounce_ch #(
    .STABLE_CYCLES(STABLE_CYCLES),
    .CNT_W        (CNT_W)
  ) u_rst_ch (
    .clk  (clk),
    .rst_n(rst_n),
    .btn  (btn_rst),
    .lvl  (rst_lvl),
    .req  (req_r)
  );

  // Arbitration: a reset request always goes first; a set yields and is held pending.
  always_comb begin
    set_want = req_s | pend_q;
    s_n_d    = STROBE_IDLE;
    r_n_d    = STROBE_IDLE;
    pend_d   = pend_q;

    if (req_r) begin
      r_n_d  = ~STROBE_IDLE;
      pend_d = set_want;
    end else if (set_want) begin
      s_n_d  = ~STROBE_IDLE;
      pend_d = 1'b0;
    end
  end

  // Output and pending-flag registers; reset drops any in-flight request.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_n_q  <= STROBE_IDLE;
      r_n_q  <= STROBE_IDLE;
      pend_q <= 1'b0;
    end else begin
      s_n_q  <= s_n_d;
      r_n_q  <= r_n_d;
      pend_q <= pend_d;
    end
  end

  assign s_n = s_n_q;
  assign r_n = r_n_q;

endmodule : sr_debounce

// File: tb/tb_sr_debounce.sv
// Bench for sr_debounce with STABLE_CYCLES=4: directed scenario table,
// hand-written reset sequences, then random stimulus against a reference model.
module tb_sr_debounce;

  localparam int S = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_set = 1'b0;
  logic btn_rst = 1'b0;
  logic s_n, r_n, set_lvl, rst_lvl;

  int n_cmp = 0;
  int n_bad = 0;

  sr_debounce #(.STABLE_CYCLES(S), .CNT_W(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_set(btn_set),
    .btn_rst(btn_rst),
    .s_n    (s_n),
    .r_n    (r_n),
    .set_lvl(set_lvl),
    .rst_lvl(rst_lvl)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, $signed(act), $signed(exp), $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A level is accepted once the synchronized input (raw delayed by two
  // edges) has disagreed with it for S consecutive edges. A rising level
  // yields a strobe two edges later; reset requests win, set requests queue.
  bit m_hs0, m_hs1, m_hr0, m_hr1;
  int m_run_s, m_run_r;
  bit m_lvl_s, m_lvl_r;
  int m_due_s[$];
  int m_due_r[$];
  int m_backlog;
  bit m_s_n = 1'b1, m_r_n = 1'b1;
  int m_edge = 0;

  task automatic chan(input bit raw, inout bit h0, inout bit h1, inout int run,
                      inout bit lvl, output bit rose);
    rose = 1'b0;
    if (h1 != lvl) begin
      run++;
      if (run == S) begin
        lvl  = !lvl;
        run  = 0;
        rose = lvl;
      end
    end else begin
      run = 0;
    end
    h1 = h0;
    h0 = raw;
  endtask

  task automatic model_edge(input bit rst, input bit bs, input bit br);
    bit rq_s, rq_r, rose_s, rose_r;
    if (!rst) begin
      m_hs0 = 0; m_hs1 = 0; m_hr0 = 0; m_hr1 = 0;
      m_run_s = 0; m_run_r = 0; m_lvl_s = 0; m_lvl_r = 0;
      m_due_s.delete(); m_due_r.delete();
      m_backlog = 0; m_s_n = 1'b1; m_r_n = 1'b1;
    end else begin
      rq_s = 1'b0;
      rq_r = 1'b0;
      if (m_due_s.size() > 0 && m_due_s[0] == m_edge) begin rq_s = 1'b1; void'(m_due_s.pop_front()); end
      if (m_due_r.size() > 0 && m_due_r[0] == m_edge) begin rq_r = 1'b1; void'(m_due_r.pop_front()); end
      if (rq_s) m_backlog++;
      m_s_n = 1'b1;
      m_r_n = 1'b1;
      if (rq_r) begin
        m_r_n = 1'b0;
      end else if (m_backlog > 0) begin
        m_s_n = 1'b0;
        m_backlog--;
      end
      chan(bs, m_hs0, m_hs1, m_run_s, m_lvl_s, rose_s);
      chan(br, m_hr0, m_hr1, m_run_r, m_lvl_r, rose_r);
      if (rose_s) m_due_s.push_back(m_edge + 2);
      if (rose_r) m_due_r.push_back(m_edge + 2);
    end
    m_edge++;
  endtask

  // One clock: drive at negedge, model the posedge, sample 1 time unit later.
  task automatic step(input bit rst, input bit bs, input bit br);
    @(negedge clk);
    rst_n   = rst;
    btn_set = bs;
    btn_rst = br;
    @(posedge clk);
    model_edge(rst, bs, br);
    #1;
  endtask

  // ---------------- directed scenario table ----------------
  typedef struct {
    string name;
    int    len;
    int    set_on, set_off, rst_on, rst_off;
    bit    toggle;
    int    reset_at, reset_len;
    int    exp_s_cyc, exp_s_cnt, exp_r_cyc, exp_r_cnt;
    bit    exp_set_lvl, exp_rst_lvl;
    int    probe_cyc;
    bit    probe_set_lvl;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int first_s, first_r, cnt_s, cnt_r;
    bit bs, br, rs;
    int hold_s, hold_r;
    bit cur_s, cur_r;

    tbl[0] = '{"set_hold",   20, 0, 20, -1, -1, 1'b0, -1, 0,  7, 1, -1, 0, 1'b1, 1'b0, 10, 1'b1};
    tbl[1] = '{"rst_glitch", 20, -1, -1, 0, 3,  1'b0, -1, 0, -1, 0, -1, 0, 1'b0, 1'b0, 10, 1'b0};
    tbl[2] = '{"both_rise",  20, 0, 100, 0, 100, 1'b0, -1, 0, 8, 1,  7, 1, 1'b1, 1'b1, 6,  1'b1};
    tbl[3] = '{"reset_mid",  30, 0, 100, -1, -1, 1'b0, 5, 2, 14, 1, -1, 0, 1'b1, 1'b0, 6,  1'b0};
    tbl[4] = '{"toggle",     55, -1, -1, -1, -1, 1'b1, -1, 0, -1, 0, -1, 0, 1'b0, 1'b0, 30, 1'b0};
    tbl[5] = '{"release",    30, 0, 20, -1, -1, 1'b0, -1, 0,  7, 1, -1, 0, 1'b0, 1'b0, 24, 1'b1};

    // Reset state.
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("reset_s_n", s_n, 1);
    check("reset_r_n", r_n, 1);
    check("reset_set_lvl", set_lvl, 0);
    check("reset_rst_lvl", rst_lvl, 0);

    for (int t = 0; t < 6; t++) begin
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      first_s = -1; first_r = -1; cnt_s = 0; cnt_r = 0;
      for (int c = 0; c < tbl[t].len; c++) begin
        if (tbl[t].toggle) bs = (c < 50) ? (c % 2 == 0) : 1'b0;
        else               bs = (c >= tbl[t].set_on) && (c < tbl[t].set_off);
        br = (c >= tbl[t].rst_on) && (c < tbl[t].rst_off);
        rs = !((c >= tbl[t].reset_at) && (c < tbl[t].reset_at + tbl[t].reset_len));
        step(rs, bs, br);
        if (!rs) check({tbl[t].name, "_s_n_in_reset"}, s_n, 1);
        check({tbl[t].name, "_mutex"}, s_n | r_n, 1);
        if (s_n == 1'b0) begin if (first_s < 0) first_s = c; cnt_s++; end
        if (r_n == 1'b0) begin if (first_r < 0) first_r = c; cnt_r++; end
        if (c == tbl[t].probe_cyc) check({tbl[t].name, "_probe_set_lvl"}, set_lvl, tbl[t].probe_set_lvl);
      end
      check({tbl[t].name, "_s_cycle"}, first_s, tbl[t].exp_s_cyc);
      check({tbl[t].name, "_s_count"}, cnt_s, tbl[t].exp_s_cnt);
      check({tbl[t].name, "_r_cycle"}, first_r, tbl[t].exp_r_cyc);
      check({tbl[t].name, "_r_count"}, cnt_r, tbl[t].exp_r_cnt);
      check({tbl[t].name, "_set_lvl"}, set_lvl, tbl[t].exp_set_lvl);
      check({tbl[t].name, "_rst_lvl"}, rst_lvl, tbl[t].exp_rst_lvl);
      if (t == 1) check("rst_glitch_cnt_zero", dut.u_rst_ch.cnt_q, 0);
    end

    // Hand sequence: reset after a set strobe with the button still held
    // clears the level; the held button then yields exactly one new strobe.
    step(1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 10; c++) step(1'b1, 1'b1, 1'b0);
    check("held_lvl_before_reset", set_lvl, 1);
    step(1'b0, 1'b1, 1'b0);
    check("held_reset_clears_lvl", set_lvl, 0);
    check("held_reset_s_n", s_n, 1);
    cnt_s = 0; first_s = -1;
    for (int c = 0; c < 20; c++) begin
      step(1'b1, 1'b1, 1'b0);
      if (s_n == 1'b0) begin if (first_s < 0) first_s = c; cnt_s++; end
    end
    check("held_after_reset_s_cycle", first_s, S + 3);
    check("held_after_reset_s_count", cnt_s, 1);

    // Random stimulus against the reference model.
    step(1'b0, 1'b0, 1'b0);
    hold_s = 0; hold_r = 0; cur_s = 0; cur_r = 0;
    for (int c = 0; c < 4000; c++) begin
      if (hold_s == 0) begin cur_s = 1'($urandom_range(0, 1)); hold_s = $urandom_range(1, 9); end
      if (hold_r == 0) begin cur_r = 1'($urandom_range(0, 1)); hold_r = $urandom_range(1, 9); end
      hold_s--;
      hold_r--;
      rs = ($urandom_range(0, 399) != 0);
      step(rs, cur_s, cur_r);
      check("rand_s_n", s_n, m_s_n);
      check("rand_r_n", r_n, m_r_n);
      check("rand_set_lvl", set_lvl, m_lvl_s);
      check("rand_rst_lvl", rst_lvl, m_lvl_r);
      check("rand_cnt_bound", (dut.u_set_ch.cnt_q <= 8'(S - 1)) && (dut.u_rst_ch.cnt_q <= 8'(S - 1)), 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_sr_debounce
